// File: rtl/regfile_mp.sv
// Multi-read-port integer register file with a post-reset clear sequence and same-cycle write bypass.
// Optional per-register pending scoreboard is enabled with `define REGFILE_SCOREBOARD_EN.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     init_done,
    input  logic                     alloc_valid,
    input  logic [ADDR_W-1:0]        alloc_addr,
    output logic [NUM_RD-1:0]        rd_pending
);

    localparam int DEPTH = 2**ADDR_W;

    typedef enum logic {CLEAR, READY} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;
    logic              ready;
    logic              wr_drop;
    logic              wr_en;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        if (state == CLEAR) begin
            clr_cnt_nxt = clr_cnt + ADDR_W'(1);
            if (&clr_cnt)
                state_nxt = READY;
        end
    end

    assign ready     = (state == READY);
    assign init_done = ready;
    assign wr_drop   = (ZERO_REG != 0) && (wr_addr == '0);
    assign wr_en     = ready && we && !wr_drop;

    // No reset on the array: the clear sequence zeroes it so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (state == CLEAR)
            mem[clr_cnt] <= '0;
        else if (wr_en)
            mem[wr_addr] <= wr_data;
    end

`ifdef REGFILE_SCOREBOARD_EN
    logic [DEPTH-1:0] pending;

    // Allocation is applied after the write clear so a same-cycle alloc leaves the bit set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else if (ready) begin
            if (wr_en)
                pending[wr_addr] <= 1'b0;
            if (alloc_valid)
                pending[alloc_addr] <= 1'b1;
            if (ZERO_REG != 0)
                pending[0] <= 1'b0;
        end
    end
`else
    logic unused_alloc;
    assign unused_alloc = ^{alloc_valid, alloc_addr};
`endif

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              is_zero;
        logic              hit;

        assign ra      = rd_addr[i*ADDR_W +: ADDR_W];
        assign is_zero = (ZERO_REG != 0) && (ra == '0);
        assign hit     = (BYPASS != 0) && wr_en && (wr_addr == ra);

        assign rd_data[i*DATA_W +: DATA_W] = (!ready || is_zero) ? '0 :
                                             hit                 ? wr_data :
                                                                   mem[ra];

`ifdef REGFILE_SCOREBOARD_EN
        logic realloc;
        assign realloc       = alloc_valid && (alloc_addr == ra);
        assign rd_pending[i] = ready && !is_zero && !(hit && !realloc) && pending[ra];
`else
        assign rd_pending[i] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two configurations (bypass+zero-reg, and neither) driven from shared stimulus.
module tb_regfile_mp;

`ifdef REGFILE_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [14:0] rd_addr;
    logic        we;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        alloc_valid;
    logic [4:0]  alloc_addr;

    logic [95:0] rd_data_a, rd_data_b;
    logic [2:0]  rd_pending_a, rd_pending_b;
    logic        init_done_a, init_done_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(3), .ZERO_REG(1), .BYPASS(1)) dut_a (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_a), .we(we),
        .wr_addr(wr_addr), .wr_data(wr_data), .init_done(init_done_a),
        .alloc_valid(alloc_valid), .alloc_addr(alloc_addr), .rd_pending(rd_pending_a));

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(3), .ZERO_REG(0), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_b), .we(we),
        .wr_addr(wr_addr), .wr_data(wr_data), .init_done(init_done_b),
        .alloc_valid(alloc_valid), .alloc_addr(alloc_addr), .rd_pending(rd_pending_b));

    // Reference model: register contents and pending flags per configuration.
    bit          ready_m;
    int          clr_m;
    logic [31:0] ma [32];
    logic [31:0] mb [32];
    bit          pa [32];
    bit          pb [32];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        ready_m = 1'b0;
        clr_m   = 0;
        for (int i = 0; i < 32; i++) begin
            pa[i] = 1'b0;
            pb[i] = 1'b0;
        end
    endtask

    task automatic model_update();
        if (rst) return;
        if (!ready_m) begin
            ma[clr_m] = '0;
            mb[clr_m] = '0;
            clr_m++;
            if (clr_m == 32) ready_m = 1'b1;
        end else begin
            if (we && wr_addr != 0) ma[wr_addr] = wr_data;
            if (we) mb[wr_addr] = wr_data;
            if (we && wr_addr != 0) pa[wr_addr] = 1'b0;
            if (alloc_valid && alloc_addr != 0) pa[alloc_addr] = 1'b1;
            if (we) pb[wr_addr] = 1'b0;
            if (alloc_valid) pb[alloc_addr] = 1'b1;
        end
    endtask

    function automatic logic [31:0] exp_rd(input bit cfg_b, input logic [4:0] a);
        if (!ready_m) return '0;
        if (cfg_b) return mb[a];
        if (a == 0) return '0;
        if (we && wr_addr == a) return wr_data;
        return ma[a];
    endfunction

    function automatic bit exp_pend(input bit cfg_b, input logic [4:0] a);
        if (!SB || !ready_m) return 1'b0;
        if (cfg_b) return pb[a];
        if (a == 0) return 1'b0;
        if (we && wr_addr == a && !(alloc_valid && alloc_addr == a)) return 1'b0;
        return pa[a];
    endfunction

    task automatic check_model();
        chk("init_done_a", 32'(init_done_a), 32'(ready_m));
        chk("init_done_b", 32'(init_done_b), 32'(ready_m));
        for (int p = 0; p < 3; p++) begin
            logic [4:0] a;
            a = rd_addr[p*5 +: 5];
            chk($sformatf("rd_a%0d@%0d", p, a), rd_data_a[p*32 +: 32], exp_rd(1'b0, a));
            chk($sformatf("rd_b%0d@%0d", p, a), rd_data_b[p*32 +: 32], exp_rd(1'b1, a));
            chk($sformatf("pend_a%0d@%0d", p, a), 32'(rd_pending_a[p]), 32'(exp_pend(1'b0, a)));
            chk($sformatf("pend_b%0d@%0d", p, a), 32'(rd_pending_b[p]), 32'(exp_pend(1'b1, a)));
        end
    endtask

    // Check current cycle at the falling edge, then advance the model at the rising edge.
    task automatic step();
        @(negedge clk);
        check_model();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic wait_ready(input string nm);
        int n;
        n = 0;
        while (init_done_a !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        chk(nm, 32'(n), 32'd32);
    endtask

    function automatic logic [4:0] rnd_addr();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 9));
    endfunction

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [14:0] ra;  // {port2, port1, port0}
        logic [95:0] ea;  // expected, bypass + zero-reg instance
        logic [95:0] eb;  // expected, plain instance
    } vec_t;

    vec_t tbl [9];

    initial begin
        tbl[0] = '{1'b1, 5'd5, 32'h12345678, {5'd5, 5'd0, 5'd5},
                   {32'h12345678, 32'h0, 32'h12345678}, {32'h0, 32'h0, 32'h0}};
        tbl[1] = '{1'b0, 5'd5, 32'h0, {5'd5, 5'd0, 5'd5},
                   {32'h12345678, 32'h0, 32'h12345678}, {32'h12345678, 32'h0, 32'h12345678}};
        tbl[2] = '{1'b1, 5'd0, 32'hFFFFFFFF, {5'd5, 5'd0, 5'd0},
                   {32'h12345678, 32'h0, 32'h0}, {32'h12345678, 32'h0, 32'h0}};
        tbl[3] = '{1'b0, 5'd0, 32'h0, {5'd5, 5'd0, 5'd0},
                   {32'h12345678, 32'h0, 32'h0}, {32'h12345678, 32'hFFFFFFFF, 32'hFFFFFFFF}};
        tbl[4] = '{1'b1, 5'd7, 32'hA5A5A5A5, {5'd7, 5'd9, 5'd7},
                   {32'hA5A5A5A5, 32'h0, 32'hA5A5A5A5}, {32'h0, 32'h0, 32'h0}};
        tbl[5] = '{1'b1, 5'd9, 32'h5A5A5A5A, {5'd7, 5'd9, 5'd7},
                   {32'hA5A5A5A5, 32'h5A5A5A5A, 32'hA5A5A5A5}, {32'hA5A5A5A5, 32'h0, 32'hA5A5A5A5}};
        tbl[6] = '{1'b0, 5'd0, 32'h0, {5'd7, 5'd9, 5'd7},
                   {32'hA5A5A5A5, 32'h5A5A5A5A, 32'hA5A5A5A5}, {32'hA5A5A5A5, 32'h5A5A5A5A, 32'hA5A5A5A5}};
        tbl[7] = '{1'b1, 5'd7, 32'h00000001, {5'd9, 5'd7, 5'd7},
                   {32'h5A5A5A5A, 32'h1, 32'h1}, {32'h5A5A5A5A, 32'hA5A5A5A5, 32'hA5A5A5A5}};
        tbl[8] = '{1'b0, 5'd0, 32'h0, {5'd9, 5'd0, 5'd7},
                   {32'h5A5A5A5A, 32'h0, 32'h1}, {32'h5A5A5A5A, 32'hFFFFFFFF, 32'h1}};

        rst = 1'b1; rd_addr = '0; we = 1'b0; wr_addr = '0; wr_data = '0;
        alloc_valid = 1'b0; alloc_addr = '0;
        model_reset();
        repeat (3) step();

        // Writes and allocations during the clear must be ignored.
        we = 1'b1; wr_addr = 5'd3; wr_data = 32'h0000DEAD;
        alloc_valid = 1'b1; alloc_addr = 5'd3;
        rd_addr = {5'd3, 5'd3, 5'd3};
        rst = 1'b0;
        wait_ready("clear_len");
        we = 1'b0; alloc_valid = 1'b0;
        #1;
        chk("reg3_a", rd_data_a[31:0], 32'h0);
        chk("reg3_b", rd_data_b[31:0], 32'h0);
        chk("reg3_pend_a", 32'(rd_pending_a[0]), 32'h0);

        foreach (tbl[r]) begin
            we = tbl[r].we; wr_addr = tbl[r].wa; wr_data = tbl[r].wd; rd_addr = tbl[r].ra;
            @(negedge clk);
            for (int p = 0; p < 3; p++) begin
                chk($sformatf("tbl%0d_a%0d", r, p), rd_data_a[p*32 +: 32], tbl[r].ea[p*32 +: 32]);
                chk($sformatf("tbl%0d_b%0d", r, p), rd_data_b[p*32 +: 32], tbl[r].eb[p*32 +: 32]);
            end
            @(posedge clk);
            model_update();
            #1;
        end

        // Scoreboard: allocate, allocate+write, then write alone.
        we = 1'b0; rd_addr = {5'd6, 5'd6, 5'd6};
        alloc_valid = 1'b1; alloc_addr = 5'd6;
        step();
        alloc_valid = 1'b0; #1;
        chk("sb_alloc_a", 32'(rd_pending_a[0]), 32'(SB));
        chk("sb_alloc_b", 32'(rd_pending_b[0]), 32'(SB));
        alloc_valid = 1'b1; we = 1'b1; wr_addr = 5'd6; wr_data = 32'hCAFEF00D;
        step();
        alloc_valid = 1'b0; we = 1'b0; #1;
        chk("sb_both_a", 32'(rd_pending_a[0]), 32'(SB));
        chk("sb_both_b", 32'(rd_pending_b[2]), 32'(SB));
        we = 1'b1; wr_data = 32'h0BADBEEF; #1;
        chk("sb_wr_byp_a", 32'(rd_pending_a[1]), 32'h0);
        chk("sb_wr_nobyp_b", 32'(rd_pending_b[1]), 32'(SB));
        step();
        we = 1'b0; #1;
        chk("sb_clr_a", 32'(rd_pending_a[0]), 32'h0);
        chk("sb_clr_b", 32'(rd_pending_b[0]), 32'h0);

        // Reset mid-clear restarts the full sequence.
        rst = 1'b1; model_reset(); #1;
        chk("rst_drop_a", 32'(init_done_a), 32'h0);
        repeat (2) step();
        rst = 1'b0;
        repeat (10) step();
        rst = 1'b1; model_reset(); #1;
        chk("rst_midclr_a", 32'(init_done_a), 32'h0);
        step();
        rst = 1'b0;
        wait_ready("clear_len2");
        we = 1'b1; wr_addr = 5'd4; wr_data = 32'h11;
        step();
        we = 1'b0; rd_addr = {5'd0, 5'd0, 5'd4}; #1;
        chk("reg4_set_a", rd_data_a[31:0], 32'h11);
        chk("reg4_set_b", rd_data_b[31:0], 32'h11);

        // Reset mid-operation.
        rst = 1'b1; model_reset(); #1;
        chk("rst_midop_a", 32'(init_done_a), 32'h0);
        chk("rst_midop_b", 32'(init_done_b), 32'h0);
        chk("rst_rd_a", rd_data_a[31:0], 32'h0);
        step();
        rst = 1'b0;
        wait_ready("clear_len3");
        #1;
        chk("reg4_zero_a", rd_data_a[31:0], 32'h0);
        chk("reg4_zero_b", rd_data_b[31:0], 32'h0);

        // Random traffic against the model.
        for (int k = 0; k < 400; k++) begin
            we          = 1'($urandom_range(0, 1));
            wr_addr     = rnd_addr();
            wr_data     = $urandom;
            alloc_valid = ($urandom_range(0, 9) < 3);
            alloc_addr  = rnd_addr();
            rd_addr     = {rnd_addr(), rnd_addr(), rnd_addr()};
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-read-port register file. It is the next-generation integer register file for the core pipeline, sitting between decode (reads) and writeback (write). Adds the following over the previous file:
- generic width, depth and read-port count;
- hardware clear sequence after reset with a ready flag;
- same-cycle write-to-read bypass;
- optional per-register pending scoreboard.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; depth = 2**ADDR_W registers
NUM_RD, 2, number of independent combinational read ports (1..4)
ZERO_REG, 1, 1 = register 0 hardwired to zero (writes dropped); 0 = register 0 is ordinary
BYPASS, 1, 1 = write data forwarded to matching read ports in the same cycle

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
rd_addr  input  NUM_RD*ADDR_W  packed read addresses; port i at [i*ADDR_W +: ADDR_W]
rd_data  output  NUM_RD*DATA_W  packed read data; port i at [i*DATA_W +: DATA_W]
we  input  1  write enable
wr_addr  input  ADDR_W  write address
wr_data  input  DATA_W  write data
init_done  output  1  high once the clear sequence has completed
alloc_valid  input  1  mark alloc_addr pending (scoreboard; see Optional Feature)
alloc_addr  input  ADDR_W  register being allocated to an in-flight producer
rd_pending  output  NUM_RD  per read port: addressed register is pending

Behaviour:
- Reset is asynchronous, active-high, on rst.
- While rst is high: state = CLEAR, clear counter = 0, init_done = 0, all pending bits = 0, rd_data = 0, rd_pending = 0.
- Array contents are not reset directly; they are zeroed by the CLEAR sequence so the array may map to RAM.
- CLEAR state:
  - one register written with 0 per cycle, address = counter, counter +1 per cycle;
  - we, alloc_valid ignored;
  - all rd_data = 0, rd_pending = 0.
- After writing address 2**ADDR_W-1 (exactly 2**ADDR_W cycles after rst deasserts), transition to READY; init_done = 1 from the next cycle.
- READY state: terminal until the next rst.
- rst asserted mid-CLEAR or mid-operation: immediate return to CLEAR with counter 0; the full sequence restarts.
- Write (READY): if we = 1, array[wr_addr] <= wr_data at the rising edge. If ZERO_REG = 1 and wr_addr = 0, the write is dropped.
- Read (READY): rd_data[i] is combinational, zero latency.
  - ZERO_REG = 1 and rd_addr[i] = 0 -> 0.
  - Else, if BYPASS = 1 and we = 1 and wr_addr = rd_addr[i] (write not dropped) -> wr_data.
  - Else -> array[rd_addr[i]].
  - BYPASS = 0: a read of the address being written returns the old value; the new value is visible the next cycle.
- Multiple read ports addressing the same register all return the same value; there are no port conflicts.
- Only one write port exists, so there is no write-write conflict.

Optional Feature:
Macro: REGFILE_SCOREBOARD_EN.
With the macro defined:
- 2**ADDR_W pending bits, cleared by rst and held 0 during CLEAR.
- alloc_valid = 1 sets pending[alloc_addr]; a (non-dropped) write clears pending[wr_addr].
- Same register allocated and written in one cycle: alloc wins, bit ends set, representing the new producer.
- ZERO_REG = 1: pending[0] is constant 0.
- rd_pending[i] = pending[rd_addr[i]], combinational. When BYPASS = 1 and a matching write occurs in that cycle, it reads 0 unless the same register is also being allocated that cycle.
Without the macro:
- No pending storage.
- rd_pending constant 0; alloc_valid and alloc_addr ignored.
- Ports still present.

Test Plan:
1. Reset/clear: pulse rst, hold we = 1 with wr_addr = 3, wr_data = 0xDEAD during CLEAR -> init_done rises exactly 32 cycles after rst falls; reading reg 3 then returns 0x00000000.
2. Write/read with bypass: write 0x12345678 to reg 5 while rd_addr[0] = 5 in the same cycle -> rd_data[0] = 0x12345678 that cycle (BYPASS = 1); with BYPASS = 0, 0 that cycle and 0x12345678 the next cycle.
3. Zero register: write 0xFFFFFFFF to reg 0, read port 1 at reg 0 -> 0x00000000 (ZERO_REG = 1); with ZERO_REG = 0 -> 0xFFFFFFFF the next cycle.
4. Multi-port: NUM_RD = 3; write reg 7 = 0xA5A5A5A5 and reg 9 = 0x5A5A5A5A; read ports at 7/9/7 -> 0xA5A5A5A5 / 0x5A5A5A5A / 0xA5A5A5A5 simultaneously.
5. Reset mid-operation: assert rst 10 cycles into CLEAR, and again after reg 4 = 0x11 is written -> init_done drops immediately; a fresh 32-cycle clear runs; reg 4 reads 0 afterwards.
6. Scoreboard (REGFILE_SCOREBOARD_EN): alloc reg 6 -> rd_pending = 1 next cycle; alloc reg 6 and write reg 6 in the same cycle -> stays 1; write reg 6 alone -> rd_pending = 0 the next cycle. Without the macro, rd_pending stays 0 throughout.
